// File: rtl/riscv_mem_bridge_pkg.sv
// Shared types for the instruction/data to unified-SRAM bridge.
// XLEN normally comes from the core's defines header; a 32-bit default applies when it is absent.
`ifndef XLEN
`define XLEN 32
`endif

package riscv_mem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_t;

    localparam int MEM_LATENCY_MIN = 1;
    localparam int MEM_LATENCY_MAX = 4;

    function automatic bit latency_ok(input int lat);
        return (lat >= MEM_LATENCY_MIN) && (lat <= MEM_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/riscv_bridge_arb.sv
// Purpose: picks fetch or data port for the next SRAM access; remembers the last grant.
// Latency: combinational grant; last-grant register updates in the RESP cycle.
// Backpressure: the losing port simply keeps its request high until a later IDLE.
module riscv_bridge_arb
    import riscv_mem_bridge_pkg::*;
#(
    parameter int DPORT_PRIORITY = 1
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_if_req,
    input  logic i_dm_req,
    input  logic i_upd,
    input  gnt_t i_upd_gnt,
    output gnt_t o_gnt
);

    gnt_t r_last;

    // Reset to fetch-last so the very first tie goes to the data port.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_last <= GNT_IF;
        end else if (i_upd) begin
            r_last <= i_upd_gnt;
        end
    end

    always_comb begin
        o_gnt = GNT_IF;
        if (i_dm_req && !i_if_req) begin
            o_gnt = GNT_DM;
        end else if (i_dm_req && i_if_req) begin
            o_gnt = ((DPORT_PRIORITY != 0) || (r_last == GNT_IF)) ? GNT_DM : GNT_IF;
        end
    end

endmodule

// File: rtl/riscv_mem_bridge.sv
// Purpose: arbitrates RV32I fetch and data ports onto one single-port SRAM, one access in flight.
// Latency: request seen in IDLE -> mem_en next cycle -> ready MEM_LATENCY+2 cycles after the request.
// Backpressure: requests are levels held until the one-cycle ready pulse; the loser waits in place.
module riscv_mem_bridge
    import riscv_mem_bridge_pkg::*;
#(
    parameter int MEM_ADDR_BIT   = 12,
    parameter int MEM_LATENCY    = 1,
    parameter int DPORT_PRIORITY = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_bridge_if_req,
    input  logic [`XLEN-1:0]        i_bridge_if_addr,
    output logic                    o_bridge_if_ready,
    output logic [`XLEN-1:0]        o_bridge_if_data,
    input  logic                    i_bridge_dm_req,
    input  logic                    i_bridge_dm_wr_en,
    input  logic [3:0]              i_bridge_dm_byte_sel,
    input  logic [`XLEN-1:0]        i_bridge_dm_addr,
    input  logic [`XLEN-1:0]        i_bridge_dm_wr_data,
    output logic                    o_bridge_dm_ready,
    output logic [`XLEN-1:0]        o_bridge_dm_rd_data,
    output logic                    o_bridge_mem_en,
    output logic                    o_bridge_mem_wr_en,
    output logic [3:0]              o_bridge_mem_byte_sel,
    output logic [MEM_ADDR_BIT-3:0] o_bridge_mem_addr,
    output logic [`XLEN-1:0]        o_bridge_mem_wr_data,
    input  logic [`XLEN-1:0]        i_bridge_mem_rd_data,
    output logic                    o_bridge_busy
);

    localparam int              AW     = MEM_ADDR_BIT - 2;
    localparam logic [1:0]      LAT_M1 = 2'(MEM_LATENCY - 1);

    generate
        if (!latency_ok(MEM_LATENCY)) begin : g_bad_latency
            $error("riscv_mem_bridge: MEM_LATENCY must be 1..4");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    gnt_t               r_gnt;
    gnt_t               w_gnt;
    logic [AW-1:0]      r_addr;
    logic               r_wr_en;
    logic [3:0]         r_byte_sel;
    logic [`XLEN-1:0]   r_wr_data;
    logic [`XLEN-1:0]   r_if_data;
    logic [`XLEN-1:0]   r_dm_data;
    logic [1:0]         r_cnt;
    logic               w_capture;
    logic               w_any_req;
    logic               w_unused_addr;

    // Byte-offset and above-SRAM bits are dropped so addresses wrap modulo SRAM size.
    assign w_unused_addr = ^{i_bridge_if_addr[1:0], i_bridge_if_addr[`XLEN-1:MEM_ADDR_BIT],
                             i_bridge_dm_addr[1:0], i_bridge_dm_addr[`XLEN-1:MEM_ADDR_BIT]};

    assign w_any_req = i_bridge_if_req | i_bridge_dm_req;

    riscv_bridge_arb #(
        .DPORT_PRIORITY (DPORT_PRIORITY)
    ) u_arb (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_if_req  (i_bridge_if_req),
        .i_dm_req  (i_bridge_dm_req),
        .i_upd     (r_state == ST_RESP),
        .i_upd_gnt (r_gnt),
        .o_gnt     (w_gnt)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_gnt      <= GNT_IF;
            r_addr     <= '0;
            r_wr_en    <= 1'b0;
            r_byte_sel <= 4'h0;
            r_wr_data  <= '0;
            r_if_data  <= '0;
            r_dm_data  <= '0;
            r_cnt      <= 2'd0;
        end else begin
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_gnt <= w_gnt;
                if (w_gnt == GNT_DM) begin
                    r_addr     <= i_bridge_dm_addr[MEM_ADDR_BIT-1:2];
                    r_wr_en    <= i_bridge_dm_wr_en;
                    r_byte_sel <= i_bridge_dm_wr_en ? i_bridge_dm_byte_sel : 4'hF;
                    r_wr_data  <= i_bridge_dm_wr_data;
                end else begin
                    r_addr     <= i_bridge_if_addr[MEM_ADDR_BIT-1:2];
                    r_wr_en    <= 1'b0;
                    r_byte_sel <= 4'hF;
                    r_wr_data  <= '0;
                end
            end

            if (r_state == ST_ISSUE) begin
                r_cnt <= LAT_M1;
            end else if ((r_state == ST_WAIT) && (r_cnt != 2'd0)) begin
                r_cnt <= r_cnt - 2'd1;
            end

            // Stores leave both read-data registers holding their previous values.
            if (w_capture && !r_wr_en) begin
                if (r_gnt == GNT_DM) begin
                    r_dm_data <= i_bridge_mem_rd_data;
                end else begin
                    r_if_data <= i_bridge_mem_rd_data;
                end
            end
        end
    end

    assign o_bridge_mem_en       = (r_state == ST_ISSUE);
    assign o_bridge_mem_wr_en    = (r_state == ST_ISSUE) && r_wr_en;
    assign o_bridge_mem_byte_sel = r_byte_sel;
    assign o_bridge_mem_addr     = r_addr;
    assign o_bridge_mem_wr_data  = r_wr_data;
    assign o_bridge_if_ready     = (r_state == ST_RESP) && (r_gnt == GNT_IF);
    assign o_bridge_dm_ready     = (r_state == ST_RESP) && (r_gnt == GNT_DM);
    assign o_bridge_if_data      = r_if_data;
    assign o_bridge_dm_rd_data   = r_dm_data;
    assign o_bridge_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_riscv_mem_bridge.sv
// Directed bench: bridge A (latency 1, data priority) and bridge B (latency 3, round-robin),
// each against a small latency-accurate SRAM model that shows data only in its valid cycle.
module tb_riscv_mem_bridge;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        a_if_req, a_dm_req, a_dm_wr_en;
    logic [31:0] a_if_addr, a_dm_addr, a_dm_wr_data;
    logic [3:0]  a_dm_byte_sel;
    logic        a_if_ready, a_dm_ready, a_mem_en, a_mem_wr_en, a_busy;
    logic [31:0] a_if_data, a_dm_rd_data, a_mem_wr_data, a_mem_rd_data;
    logic [3:0]  a_mem_byte_sel;
    logic [9:0]  a_mem_addr;

    logic        b_if_req, b_dm_req, b_dm_wr_en;
    logic [31:0] b_if_addr, b_dm_addr, b_dm_wr_data;
    logic [3:0]  b_dm_byte_sel;
    logic        b_if_ready, b_dm_ready, b_mem_en, b_mem_wr_en, b_busy;
    logic [31:0] b_if_data, b_dm_rd_data, b_mem_wr_data, b_mem_rd_data;
    logic [3:0]  b_mem_byte_sel;
    logic [9:0]  b_mem_addr;

    riscv_mem_bridge #(.MEM_ADDR_BIT(12), .MEM_LATENCY(1), .DPORT_PRIORITY(1)) dut_a (
        .i_clk(clk), .i_rstn(rstn),
        .i_bridge_if_req(a_if_req), .i_bridge_if_addr(a_if_addr),
        .o_bridge_if_ready(a_if_ready), .o_bridge_if_data(a_if_data),
        .i_bridge_dm_req(a_dm_req), .i_bridge_dm_wr_en(a_dm_wr_en),
        .i_bridge_dm_byte_sel(a_dm_byte_sel), .i_bridge_dm_addr(a_dm_addr),
        .i_bridge_dm_wr_data(a_dm_wr_data),
        .o_bridge_dm_ready(a_dm_ready), .o_bridge_dm_rd_data(a_dm_rd_data),
        .o_bridge_mem_en(a_mem_en), .o_bridge_mem_wr_en(a_mem_wr_en),
        .o_bridge_mem_byte_sel(a_mem_byte_sel), .o_bridge_mem_addr(a_mem_addr),
        .o_bridge_mem_wr_data(a_mem_wr_data), .i_bridge_mem_rd_data(a_mem_rd_data),
        .o_bridge_busy(a_busy)
    );

    riscv_mem_bridge #(.MEM_ADDR_BIT(12), .MEM_LATENCY(3), .DPORT_PRIORITY(0)) dut_b (
        .i_clk(clk), .i_rstn(rstn),
        .i_bridge_if_req(b_if_req), .i_bridge_if_addr(b_if_addr),
        .o_bridge_if_ready(b_if_ready), .o_bridge_if_data(b_if_data),
        .i_bridge_dm_req(b_dm_req), .i_bridge_dm_wr_en(b_dm_wr_en),
        .i_bridge_dm_byte_sel(b_dm_byte_sel), .i_bridge_dm_addr(b_dm_addr),
        .i_bridge_dm_wr_data(b_dm_wr_data),
        .o_bridge_dm_ready(b_dm_ready), .o_bridge_dm_rd_data(b_dm_rd_data),
        .o_bridge_mem_en(b_mem_en), .o_bridge_mem_wr_en(b_mem_wr_en),
        .o_bridge_mem_byte_sel(b_mem_byte_sel), .o_bridge_mem_addr(b_mem_addr),
        .o_bridge_mem_wr_data(b_mem_wr_data), .i_bridge_mem_rd_data(b_mem_rd_data),
        .o_bridge_busy(b_busy)
    );

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    logic        a_vld;
    logic [31:0] a_dat;
    logic [2:0]  b_vld;
    logic [31:0] b_dat [3];

    assign a_mem_rd_data = a_vld    ? a_dat    : 32'hBAD0_BAD0;
    assign b_mem_rd_data = b_vld[2] ? b_dat[2] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 1024; i++) begin
                mem_a[i] <= 32'h0;
                mem_b[i] <= 32'h0;
            end
            mem_a[4]  <= 32'h0051_0513;
            mem_a[5]  <= 32'h1111_1111;
            mem_a[1]  <= 32'h2222_2222;
            mem_b[16] <= 32'hAAAA_0001;
            mem_b[17] <= 32'hBBBB_0002;
            a_vld     <= 1'b0;
            b_vld     <= 3'b000;
        end else begin
            a_vld    <= a_mem_en;
            a_dat    <= mem_a[a_mem_addr];
            b_vld    <= {b_vld[1:0], b_mem_en};
            b_dat[0] <= mem_b[b_mem_addr];
            b_dat[1] <= b_dat[0];
            b_dat[2] <= b_dat[1];
            for (int i = 0; i < 4; i++) begin
                if (a_mem_en && a_mem_wr_en && a_mem_byte_sel[i])
                    mem_a[a_mem_addr][8*i +: 8] <= a_mem_wr_data[8*i +: 8];
                if (b_mem_en && b_mem_wr_en && b_mem_byte_sel[i])
                    mem_b[b_mem_addr][8*i +: 8] <= b_mem_wr_data[8*i +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of the sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        a_if_req = 0; a_if_addr = 0; a_dm_req = 0; a_dm_wr_en = 0;
        a_dm_byte_sel = 0; a_dm_addr = 0; a_dm_wr_data = 0;
        b_if_req = 0; b_if_addr = 0; b_dm_req = 0; b_dm_wr_en = 0;
        b_dm_byte_sel = 0; b_dm_addr = 0; b_dm_wr_data = 0;
        step(3);
        chk("a_reset_ctrl", {27'd0, a_mem_en, a_mem_wr_en, a_if_ready, a_dm_ready, a_busy}, 32'd0);
        chk("a_reset_data", a_if_data | a_dm_rd_data | a_mem_wr_data, 32'd0);
        chk("a_reset_mem",  {18'd0, a_mem_addr, a_mem_byte_sel}, 32'd0);
        chk("b_reset_ctrl", {27'd0, b_mem_en, b_mem_wr_en, b_if_ready, b_dm_ready, b_busy}, 32'd0);
        rstn = 1'b1;
        step(1);

        // A: single fetch at 0x10, ready in cycle 3
        a_if_req = 1; a_if_addr = 32'h0000_0010;
        step(1);
        chk("a_fetch_mem_en",   a_mem_en, 1);
        chk("a_fetch_mem_addr", a_mem_addr, 4);
        chk("a_fetch_byte_sel", a_mem_byte_sel, 4'hF);
        chk("a_fetch_wr_en",    a_mem_wr_en, 0);
        step(1);
        chk("a_fetch_c2_ready", a_if_ready, 0);
        chk("a_fetch_c2_busy",  a_busy, 1);
        step(1);
        chk("a_fetch_ready", a_if_ready, 1);
        chk("a_fetch_data",  a_if_data, 32'h0051_0513);
        a_if_req = 0;
        step(1);
        chk("a_fetch_idle", {a_busy, a_if_ready}, 0);

        // A: tie with data priority; data load at 0x1004 wraps to word 1
        a_if_req = 1; a_if_addr = 32'h0000_0014;
        a_dm_req = 1; a_dm_wr_en = 0; a_dm_addr = 32'h0000_1004;
        step(1);
        chk("a_tie_first_addr", a_mem_addr, 1);
        step(2);
        chk("a_tie_dm_ready", a_dm_ready, 1);
        chk("a_tie_if_wait",  a_if_ready, 0);
        chk("a_tie_dm_data",  a_dm_rd_data, 32'h2222_2222);
        a_dm_req = 0;
        step(3);
        chk("a_tie_if_early", a_if_ready, 0);
        step(1);
        chk("a_tie_if_ready", a_if_ready, 1);
        chk("a_tie_if_data",  a_if_data, 32'h1111_1111);
        chk("a_tie_dm_held",  a_dm_rd_data, 32'h2222_2222);
        a_if_req = 0;
        step(1);

        // A: reset asserted during WAIT, then a fresh fetch
        a_if_req = 1; a_if_addr = 32'h0000_0014;
        step(2);
        chk("a_rst_pre_busy", a_busy, 1);
        rstn = 1'b0;
        #1;
        chk("a_rst_async_ctrl", {27'd0, a_mem_en, a_mem_wr_en, a_if_ready, a_dm_ready, a_busy}, 32'd0);
        chk("a_rst_async_data", a_if_data | a_dm_rd_data, 32'd0);
        a_if_req = 0;
        step(2);
        rstn = 1'b1;
        step(1);
        a_if_req = 1; a_if_addr = 32'h0000_0010;
        step(1);
        chk("a_post_rst_c1", {a_mem_en, a_if_ready}, 2'b10);
        step(1);
        chk("a_post_rst_c2_ready", a_if_ready, 0);
        step(1);
        chk("a_post_rst_ready", a_if_ready, 1);
        chk("a_post_rst_data",  a_if_data, 32'h0051_0513);
        a_if_req = 0;
        step(1);

        // B: round-robin with both ports held for four accesses: DM, IF, DM, IF
        b_if_req = 1; b_if_addr = 32'h0000_0040;
        b_dm_req = 1; b_dm_wr_en = 0; b_dm_addr = 32'h0000_0044;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("b_rr_mem_en",   b_mem_en, 1);
            chk("b_rr_mem_addr", b_mem_addr, (k % 2 == 0) ? 32'd17 : 32'd16);
            step(3);
            chk("b_rr_no_early_ready", {b_dm_ready, b_if_ready}, 0);
            step(1);
            chk("b_rr_dm_ready", b_dm_ready, (k % 2 == 0) ? 1 : 0);
            chk("b_rr_if_ready", b_if_ready, (k % 2 == 0) ? 0 : 1);
            if (k % 2 == 0) chk("b_rr_dm_data", b_dm_rd_data, 32'hBBBB_0002);
            else            chk("b_rr_if_data", b_if_data, 32'hAAAA_0001);
            if (k == 3) begin
                b_if_req = 0;
                b_dm_req = 0;
            end
            step(1);
        end

        // B: store 0xDEADBEEF lanes 0-1 at 0x20, then load it back
        b_dm_req = 1; b_dm_wr_en = 1; b_dm_byte_sel = 4'b0011;
        b_dm_addr = 32'h0000_0020; b_dm_wr_data = 32'hDEAD_BEEF;
        step(1);
        chk("b_st_mem_wr_en",   {b_mem_en, b_mem_wr_en}, 2'b11);
        chk("b_st_byte_sel",    b_mem_byte_sel, 4'b0011);
        chk("b_st_mem_addr",    b_mem_addr, 8);
        chk("b_st_mem_wr_data", b_mem_wr_data, 32'hDEAD_BEEF);
        step(3);
        chk("b_st_early", b_dm_ready, 0);
        step(1);
        chk("b_st_ready",      b_dm_ready, 1);
        chk("b_st_rdata_held", b_dm_rd_data, 32'hBBBB_0002);
        b_dm_req = 0; b_dm_wr_en = 0;
        step(1);
        b_dm_req = 1; b_dm_addr = 32'h0000_0020;
        step(1);
        chk("b_ld_byte_sel", b_mem_byte_sel, 4'hF);
        chk("b_ld_wr_en",    b_mem_wr_en, 0);
        chk("b_ld_mem_addr", b_mem_addr, 8);
        step(3);
        chk("b_ld_early", b_dm_ready, 0);
        step(1);
        chk("b_ld_ready", b_dm_ready, 1);
        chk("b_ld_data",  b_dm_rd_data, 32'h0000_BEEF);
        b_dm_req = 0;
        step(1);
        chk("b_final_idle", b_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
